// File: rtl/exec_dispatch.sv
// rtl/exec_dispatch.sv - issue instructions to functional units and arbitrate their results onto one write-back port
module exec_dispatch #(
   parameter int NUM_UNITS = 4,
   parameter int W_WORD    = 32,
   parameter int W_PREG    = 6
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        order,
   input  logic [NUM_UNITS-1:0]        unit_sel,
   input  logic [W_PREG-1:0]           pa_rd,
   input  logic                        flush,
   output logic                        accepted,
   output logic [NUM_UNITS-1:0]        u_order,
   input  logic [NUM_UNITS-1:0]        u_accepted,
   input  logic [NUM_UNITS-1:0]        u_done,
   input  logic [NUM_UNITS*W_WORD-1:0] u_rd,
   output logic                        wb_valid,
   output logic [W_PREG-1:0]           wb_pa,
   output logic [W_WORD-1:0]           wb_data,
   output logic                        busy_out,
   output logic                        err
);

   localparam int W_RR = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]           state_q [NUM_UNITS];
   logic [1:0]           state_d [NUM_UNITS];
   logic [W_PREG-1:0]    tag_q   [NUM_UNITS];
   logic [W_PREG-1:0]    tag_d   [NUM_UNITS];
   logic [W_WORD-1:0]    buf_q   [NUM_UNITS];
   logic [W_WORD-1:0]    buf_d   [NUM_UNITS];
   logic [W_RR-1:0]      rr_q, rr_d;
   logic                 wb_valid_q, wb_valid_d;
   logic [W_PREG-1:0]    wb_pa_q, wb_pa_d;
   logic [W_WORD-1:0]    wb_data_q, wb_data_d;
   logic                 err_q, err_d;

   logic [NUM_UNITS-1:0] sel;
   logic [NUM_UNITS-1:0] take;
   logic [NUM_UNITS-1:0] grant;
   logic                 gnt_any;
   int                   gnt_idx;

   // State register for all units, arbiter pointer and write-back port
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            state_q[i] <= ST_IDLE;
            tag_q[i]   <= '0;
            buf_q[i]   <= '0;
         end
         rr_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_pa_q    <= '0;
         wb_data_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            state_q[i] <= state_d[i];
            tag_q[i]   <= tag_d[i];
            buf_q[i]   <= buf_d[i];
         end
         rr_q       <= rr_d;
         wb_valid_q <= wb_valid_d;
         wb_pa_q    <= wb_pa_d;
         wb_data_q  <= wb_data_d;
         err_q      <= err_d;
      end
   end

   // Output decode: lowest-set-bit select, issue strobes, accept and busy
   always_comb begin
      logic found;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (unit_sel[i] && !found) begin
            sel[i] = 1'b1;
            found  = 1'b1;
         end
      end
      busy_out = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         u_order[i] = order & ~flush & sel[i] & (state_q[i] == ST_IDLE);
         busy_out   = busy_out | (state_q[i] != ST_IDLE);
      end
      take     = u_order & u_accepted;
      accepted = |take;
   end

   // Round-robin grant among HOLD units, searching upward from rr; flush suppresses grants
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = 0;
      for (int j = 0; j < NUM_UNITS; j++) begin
         for (int i = 0; i < NUM_UNITS; i++) begin
            if (!gnt_any && !flush && (state_q[i] == ST_HOLD) &&
                (((int'(rr_q) + j) % NUM_UNITS) == i)) begin
               gnt_any  = 1'b1;
               gnt_idx  = i;
               grant[i] = 1'b1;
            end
         end
      end
   end

   // Per-unit next state; u_done on a unit that is not expecting it latches err
   always_comb begin
      err_d = err_q;
      for (int i = 0; i < NUM_UNITS; i++) begin
         state_d[i] = state_q[i];
         tag_d[i]   = tag_q[i];
         buf_d[i]   = buf_q[i];
         if (u_done[i] && ((state_q[i] == ST_HOLD) ||
                           ((state_q[i] == ST_IDLE) && !take[i]))) begin
            err_d = 1'b1;
         end
         if (flush) begin
            case (state_q[i])
               ST_BUSY: state_d[i] = u_done[i] ? ST_IDLE : ST_DRAIN;
               ST_HOLD: state_d[i] = ST_IDLE;
               default: ;
            endcase
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  if (take[i]) begin
                     tag_d[i] = pa_rd;
                     if (u_done[i]) begin
                        state_d[i] = ST_HOLD;
                        buf_d[i]   = u_rd[i*W_WORD +: W_WORD];
                     end else begin
                        state_d[i] = ST_BUSY;
                     end
                  end
               end
               ST_BUSY: begin
                  if (u_done[i]) begin
                     state_d[i] = ST_HOLD;
                     buf_d[i]   = u_rd[i*W_WORD +: W_WORD];
                  end
               end
               ST_HOLD: begin
                  if (grant[i]) state_d[i] = ST_IDLE;
               end
               ST_DRAIN: begin
                  if (u_done[i]) state_d[i] = ST_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   // Write-back port and pointer update; address/data hold when nothing is granted
   always_comb begin
      wb_valid_d = gnt_any;
      wb_pa_d    = wb_pa_q;
      wb_data_d  = wb_data_q;
      rr_d       = rr_q;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (grant[i]) begin
            wb_pa_d   = tag_q[i];
            wb_data_d = buf_q[i];
         end
      end
      if (gnt_any) rr_d = W_RR'((gnt_idx + 1) % NUM_UNITS);
   end

   assign wb_valid = wb_valid_q;
   assign wb_pa    = wb_pa_q;
   assign wb_data  = wb_data_q;
   assign err      = err_q;

endmodule

// File: doc/exec_dispatch.md
EXEC_DISPATCH -- requirements
Module: exec_dispatch

Interface
REQ-001 Parameter NUM_UNITS, default 4: number of functional-unit ports (2..8).
REQ-002 Parameter W_WORD, default 32: result data width.
REQ-003 Parameter W_PREG, default 6: physical destination register address width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 order  in  1  instruction window offers one instruction this cycle.
REQ-007 unit_sel  in  NUM_UNITS  target unit select, one-hot expected.
REQ-008 pa_rd  in  W_PREG  destination physical register of the offered instruction.
REQ-009 flush  in  1  discard all in-flight and buffered results (branch hazard).
REQ-010 accepted  out  1  offered instruction taken this cycle (combinational).
REQ-011 u_order  out  NUM_UNITS  per-unit issue strobe (combinational).
REQ-012 u_accepted  in  NUM_UNITS  per-unit accept, same cycle as u_order.
REQ-013 u_done  in  NUM_UNITS  per-unit single-cycle completion pulse.
REQ-014 u_rd  in  NUM_UNITS*W_WORD  per-unit result, valid with u_done; unit i at bits [i*W_WORD +: W_WORD].
REQ-015 wb_valid  out  1  registered write-back strobe to register_manage.
REQ-016 wb_pa  out  W_PREG  registered write-back address.
REQ-017 wb_data  out  W_WORD  registered write-back data.
REQ-018 busy_out  out  1  high when any unit is not IDLE.
REQ-019 err  out  1  sticky protocol-error flag.

Function
REQ-020 Each unit i SHALL hold a state: IDLE, BUSY, HOLD, DRAIN, plus a W_PREG tag and W_WORD result buffer.
REQ-021 Effective selection SHALL be the lowest set bit of unit_sel; unit_sel==0 SHALL issue nothing.
REQ-022 u_order[i] SHALL equal order & ~flush & sel[i] & (state[i]==IDLE).
REQ-023 accepted SHALL equal OR over i of u_order[i] & u_accepted[i].
REQ-024 On accept with u_done[i] low: IDLE->BUSY, tag<=pa_rd.
REQ-025 On accept with u_done[i] high (zero-latency unit): IDLE->HOLD, tag<=pa_rd, buffer<=u_rd[i].
REQ-026 BUSY with u_done[i]: ->HOLD, buffer<=u_rd[i].
REQ-027 HOLD: stays until granted write-back; granted cycle ->IDLE, so unit may accept again the following cycle.
REQ-028 DRAIN: stays until u_done[i], then ->IDLE with result dropped.
REQ-029 Flush (overrides all else in that cycle): HOLD->IDLE, BUSY->DRAIN (also if u_done same cycle: ->IDLE), IDLE/DRAIN unchanged; no issue and no grant that cycle; already-registered wb outputs of the flush cycle stand.
REQ-030 Arbiter SHALL grant at most one HOLD unit per cycle, round-robin starting from pointer rr; after a grant to unit k, rr<=(k+1) mod NUM_UNITS.
REQ-031 Grant to unit k SHALL register wb_valid<=1, wb_pa<=tag[k], wb_data<=buffer[k]; no grant registers wb_valid<=0 and holds wb_pa/wb_data.
REQ-032 Latency: u_done at cycle t on an otherwise idle block SHALL produce wb_valid at cycle t+2 (HOLD at t+1, grant t+1, output visible t+2).
REQ-033 u_done[i] while IDLE or HOLD SHALL be ignored and set err; err clears only on reset.
REQ-034 busy_out SHALL be combinational OR of (state!=IDLE) over all units.

Reset
REQ-035 While rstn low at a clock edge: all units IDLE, tags/buffers 0, rr 0, wb_valid 0, wb_pa 0, wb_data 0, err 0.
REQ-036 Reset mid-operation SHALL discard all in-flight work; u_done arriving after reset release on an IDLE unit SHALL set err.
REQ-037 Combinational outputs SHALL follow REQ-022/023 from reset state (u_order valid the first cycle after release).

Verification
REQ-038 Unit 1 accepts pa_rd=5 at t0, u_done[1] with 0xDEADBEEF at t3 -> wb_valid=1, wb_pa=5, wb_data=0xDEADBEEF at t5 only; busy_out high t1..t4.
REQ-039 Zero-latency: unit 0 order+accepted+done same cycle t0, data 0x12, pa 3 -> wb at t2; second order to unit 0 at t1 refused (accepted=0), accepted at t2.
REQ-040 Units 0,2,3 all done same cycle, rr=0 -> write-back order 0,2,3 on three consecutive cycles; rr ends at 0.
REQ-041 Unit 2 BUSY, flush at t0, u_done[2] at t2 -> no wb_valid ever, unit 2 IDLE at t3, err stays 0.
REQ-042 unit_sel=4'b0110 with both IDLE -> only u_order[1] high; unit_sel=0 -> accepted=0.
REQ-043 u_done[3] pulsed while unit 3 IDLE -> err=1 next cycle and remains 1 until rstn low.
